dbg_reg_snapshot: RTL and testbench
===================================

Name: dbg_reg_snapshot

Overview:
- Responder side of the debug-screen register read interface: the screen drives regAddr and this block returns regData.
- Taps the CPU register-file writeback port and keeps a live copy of all 32 architectural registers.
- At each vertical-sync start it copies the live set into a shadow bank, one register per cycle, so every displayed frame shows one coherent snapshot.
- Sits between the CPU core and vga_debug_screen, in the pixel clock domain.

Parameters:
- ADDR_W, 5, register address width (2**ADDR_W registers)
- DATA_W, 32, register data width
- VSYNC_POL, 0, active level of vsync (0 = active-low pulse)
- CNT_W, 16, width of frame snapshot counter

Ports:
- clk  input  1  clock (the pixel/VGA clock, shared with the CPU tap)
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  CPU register write enable
- wr_addr  input  ADDR_W  CPU register write address
- wr_data  input  DATA_W  CPU register write data
- vsync  input  1  vsync from the screen timing generator, same clock domain
- freeze  input  1  1 = hold the current snapshot and start no new copies
- regAddr  input  ADDR_W  register address from the screen
- regData  output  DATA_W  shadow[regAddr], combinational
- snap_busy  output  1  high while a copy is in progress
- frame_cnt  output  CNT_W  number of completed snapshots, wraps at 2**CNT_W

Behaviour:
- Reset: clk and reset only; reset is asynchronous and active-high. Asserting reset clears:
  - live[] and shadow[] to 0
  - snap_busy to 0, frame_cnt to 0, copy index to 0
  - the vsync delay register to the inactive level (!VSYNC_POL)
  - FSM to IDLE
- Reset mid-copy aborts the copy; shadow returns to all-zero.
- Live bank:
  - On a clk edge with wr_en=1 and wr_addr!=0: live[wr_addr] <= wr_data.
  - Writes to address 0 are ignored; live[0] and shadow[0] are always 0.
- Start detection: start = (vsync==VSYNC_POL) && (vsync_d!=VSYNC_POL), where vsync_d is vsync registered by one cycle.
- FSM has two states, IDLE and COPY.
  - IDLE -> COPY when start && !freeze. idx <= 0, snap_busy <= 1 on the same edge.
  - COPY: each cycle shadow[idx] <= src, idx <= idx+1.
    - src = wr_data if wr_en && wr_addr==idx && idx!=0 (same-cycle write bypass); otherwise src = live[idx].
  - COPY -> IDLE on the cycle that writes idx = 2**ADDR_W-1. snap_busy <= 0 and frame_cnt <= frame_cnt+1 on that same edge.
- Copy duration: exactly 2**ADDR_W cycles (32 by default).
  - snap_busy is high from the edge after start to the edge after the last copy.
- Start during COPY is ignored; no queueing.
- freeze asserted during COPY does not stop that copy. It blocks only later starts.
- Writes during COPY:
  - to an index already copied: reach the next snapshot only
  - to the index being copied this cycle or a later one: appear in this snapshot
- regData = shadow[regAddr] with zero latency.
  - During COPY it may show a mix of old and new entries. This is acceptable because the copy runs inside vertical blanking.
- frame_cnt wraps from 2**CNT_W-1 to 0.

Decomposition:
- Package vga_dbg_pkg holds:
  - ADDR_W and DATA_W defaults
  - NREGS = 2**ADDR_W
  - typedef reg_addr_t, reg_data_t
  - enum snap_state_t {IDLE, COPY}
- One sub-module, dbg_reg_bank: a parameterised 2**ADDR_W x DATA_W array with one synchronous write port, one combinational read port, a zero register at index 0 and asynchronous clear.
  - The top instantiates it twice (live and shadow) and contains the FSM, edge detect and counter.

Test Plan:
1. Reset then idle: with reset=1, set regAddr=5 → regData=0, snap_busy=0, frame_cnt=0. Release reset with no vsync edge → all remain 0.
2. Basic snapshot: write r5=0xDEADBEEF and r31=0x12345678, then drive one vsync low pulse (VSYNC_POL=0) → snap_busy high for exactly 32 cycles, frame_cnt=1, regAddr=5 → 0xDEADBEEF, regAddr=31 → 0x12345678.
3. Coherency and bypass: start a copy, then write r3=0xAAAA5555 at copy idx 10 and r20=0x0F0F0F0F exactly when idx=20 → after the copy shadow r3 holds its old value, r20=0x0F0F0F0F. The next frame shows r3=0xAAAA5555.
4. r0 and retrigger: write r0=0xFFFFFFFF → regData for addr 0 stays 0. A second vsync edge during COPY → frame_cnt increments by 1 only and the copy takes 32 cycles, not more.
5. Freeze: set freeze=1, change r7, pulse vsync 3 times → shadow r7 unchanged, frame_cnt unchanged. Raise freeze at copy idx 4 → that copy completes and frame_cnt increments.
6. Reset mid-copy: assert reset at idx 15 → snap_busy=0 immediately, all regData=0, frame_cnt=0. The next vsync gives a normal 32-cycle copy.

Source files
------------

// File: rtl/vga_dbg_pkg.sv
// Shared types and defaults for the debug-screen register snapshot path.
package vga_dbg_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 2**ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        COPY = 1'b1
    } snap_state_t;

endpackage

// File: rtl/dbg_reg_bank.sv
// Register bank: one synchronous write port, one combinational read port,
// entry 0 hardwired to zero, whole array cleared by async reset.
module dbg_reg_bank #(
    parameter int unsigned ADDR_W = vga_dbg_pkg::ADDR_W,
    parameter int unsigned DATA_W = vga_dbg_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];

    // Next array contents; writes to entry 0 are dropped so it reads as zero
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    // Array storage with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dbg_reg_snapshot.sv
// Live copy of the CPU register file plus a per-frame shadow snapshot
// served to the debug screen; the copy is triggered by vsync start.
module dbg_reg_snapshot #(
    parameter int unsigned ADDR_W    = vga_dbg_pkg::ADDR_W,
    parameter int unsigned DATA_W    = vga_dbg_pkg::DATA_W,
    parameter int unsigned VSYNC_POL = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              vsync,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] regAddr,
    output logic [DATA_W-1:0] regData,
    output logic              snap_busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    import vga_dbg_pkg::*;

    localparam int unsigned LAST_IDX = 2**ADDR_W - 1;
    localparam logic        VS_ACT   = 1'(VSYNC_POL);

    snap_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              vsync_q, vsync_d;

    logic              start_c;
    logic [DATA_W-1:0] live_rdata;
    logic              shad_we;
    logic [DATA_W-1:0] shad_wdata;

    // Live bank tracks every CPU writeback; read port walks the copy index
    dbg_reg_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_live (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (idx_q),
        .rdata (live_rdata)
    );

    // Shadow bank holds the frame snapshot shown on screen
    dbg_reg_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_shadow (
        .clk   (clk),
        .reset (reset),
        .we    (shad_we),
        .waddr (idx_q),
        .wdata (shad_wdata),
        .raddr (regAddr),
        .rdata (regData)
    );

    // Vsync start edge, copy source with same-cycle write bypass, FSM next state
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;
        vsync_d     = vsync;
        shad_we     = 1'b0;
        shad_wdata  = live_rdata;

        start_c = (vsync == VS_ACT) && (vsync_q != VS_ACT);

        if (wr_en && (wr_addr == idx_q) && (idx_q != '0)) begin
            shad_wdata = wr_data;
        end

        case (state_q)
            IDLE: begin
                if (start_c && !freeze) begin
                    state_d = COPY;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            COPY: begin
                shad_we = 1'b1;
                idx_d   = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(LAST_IDX)) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            vsync_q     <= ~VS_ACT;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= vsync_d;
        end
    end

    assign snap_busy = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dbg_reg_snapshot.sv
// Bench for dbg_reg_snapshot: directed scenarios plus random traffic,
// checked against a behavioural frame-snapshot model.
module tb_dbg_reg_snapshot;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          vsync;
    logic          freeze;
    logic [AW-1:0] regAddr;
    logic [DW-1:0] regData;
    logic          snap_busy;
    logic [CW-1:0] frame_cnt;

    dbg_reg_snapshot #(.ADDR_W(AW), .DATA_W(DW), .VSYNC_POL(0), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .vsync     (vsync),
        .freeze    (freeze),
        .regAddr   (regAddr),
        .regData   (regData),
        .snap_busy (snap_busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cycles;

    // Model: a frame snapshot samples register k exactly k+1 cycles after the
    // vsync start edge; a write landing on that same cycle is what gets captured.
    logic [DW-1:0] m_live   [NR];
    logic [DW-1:0] m_shadow [NR];
    int            m_copy_age;   // -1 when no snapshot is being taken
    logic          m_vs_prev;
    int            m_frames;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            m_live[i]   = '0;
            m_shadow[i] = '0;
        end
        m_copy_age = -1;
        m_vs_prev  = 1'b1;
        m_frames   = 0;
    endfunction

    function automatic void model_edge(input logic we, input int wa, input logic [DW-1:0] wd,
                                       input logic vs, input logic fr);
        logic [DW-1:0] new_live [NR];
        new_live = m_live;
        if (we && wa != 0) new_live[wa] = wd;
        if (m_copy_age >= 0) begin
            // register being sampled this cycle sees this cycle's write
            m_shadow[m_copy_age] = new_live[m_copy_age];
            m_copy_age++;
            if (m_copy_age == NR) begin
                m_copy_age = -1;
                m_frames   = (m_frames + 1) % (1 << CW);
            end
        end else if (vs == 1'b0 && m_vs_prev == 1'b1 && !fr) begin
            m_copy_age = 0;
        end
        m_live    = new_live;
        m_vs_prev = vs;
    endfunction

    // One clock cycle: drive at negedge, model on posedge, compare at next negedge
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic vs, input logic fr, input logic [AW-1:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; vsync = vs; freeze = fr; regAddr = ra;
        @(posedge clk);
        model_edge(we, int'(wa), wd, vs, fr);
        @(negedge clk);
        if (snap_busy) busy_cycles++;
        check("snap_busy", 64'(snap_busy), 64'(m_copy_age >= 0));
        check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
        check("regData", 64'(regData), 64'(m_shadow[ra]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b1, freeze, regAddr);
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        cyc(1'b1, AW'(a), d, 1'b1, freeze, regAddr);
    endtask

    task automatic pulse();
        cyc(1'b0, '0, '0, 1'b0, freeze, regAddr);
    endtask

    task automatic expect_reg(input string tag, input int a, input logic [DW-1:0] v);
        regAddr = AW'(a);
        #1;
        check(tag, 64'(regData), 64'(v));
    endtask

    initial begin
        int base;
        model_reset();
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        vsync = 1'b1; freeze = 1'b0; regAddr = AW'(5);
        busy_cycles = 0;

        // 1: reset and idle
        repeat (2) @(negedge clk);
        check("rst_regData", 64'(regData), 64'd0);
        check("rst_busy", 64'(snap_busy), 64'd0);
        check("rst_frame", 64'(frame_cnt), 64'd0);
        reset = 1'b0;
        idle(5);
        check("idle_frame", 64'(frame_cnt), 64'd0);

        // 2: basic snapshot
        wr(5, 32'hDEADBEEF);
        wr(31, 32'h12345678);
        busy_cycles = 0;
        pulse();
        idle(36);
        check("basic_busy_len", 64'(busy_cycles), 64'd32);
        check("basic_frame", 64'(frame_cnt), 64'd1);
        expect_reg("basic_r5", 5, 32'hDEADBEEF);
        expect_reg("basic_r31", 31, 32'h12345678);

        // 3: coherency and bypass; cycle j after the pulse samples idx j-1
        wr(3, 32'h33333333);
        pulse();
        idle(10);
        wr(3, 32'hAAAA5555);          // idx 10
        idle(9);
        wr(20, 32'h0F0F0F0F);         // idx 20
        idle(14);
        expect_reg("coh_r3_old", 3, 32'h33333333);
        expect_reg("coh_r20_bypass", 20, 32'h0F0F0F0F);
        pulse();
        idle(34);
        expect_reg("coh_r3_new", 3, 32'hAAAA5555);
        check("coh_frame", 64'(frame_cnt), 64'd3);

        // 4: r0 ignored, retrigger during copy ignored
        wr(0, 32'hFFFFFFFF);
        pulse();
        idle(34);
        expect_reg("r0_zero", 0, 32'h0);
        busy_cycles = 0;
        base = int'(frame_cnt);
        pulse();
        idle(4);
        pulse();
        idle(36);
        check("retrig_busy_len", 64'(busy_cycles), 64'd32);
        check("retrig_frame", 64'(frame_cnt), 64'(base + 1));

        // 5: freeze
        base = int'(frame_cnt);
        freeze = 1'b1;
        wr(7, 32'h77777777);
        for (int p = 0; p < 3; p++) begin pulse(); idle(5); end
        expect_reg("frz_r7", 7, 32'h0);
        check("frz_frame", 64'(frame_cnt), 64'(base));
        freeze = 1'b0;
        pulse();
        idle(4);
        freeze = 1'b1;                // raised at idx 4
        idle(32);
        check("frz_mid_frame", 64'(frame_cnt), 64'(base + 1));
        expect_reg("frz_mid_r7", 7, 32'h77777777);
        freeze = 1'b0;

        // 6: reset mid-copy
        pulse();
        idle(16);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 64'(snap_busy), 64'd0);
        check("midrst_frame", 64'(frame_cnt), 64'd0);
        for (int a = 0; a < NR; a += 5) begin
            regAddr = AW'(a);
            #0.1;
            check("midrst_reg", 64'(regData), 64'd0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        busy_cycles = 0;
        pulse();
        idle(36);
        check("post_rst_busy_len", 64'(busy_cycles), 64'd32);
        check("post_rst_frame", 64'(frame_cnt), 64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), DW'($urandom),
                ($urandom_range(0, 39) != 0), ($urandom_range(0, 9) == 0),
                AW'($urandom_range(0, NR - 1)));
        end
        idle(40);
        for (int a = 0; a < NR; a++) begin
            expect_reg("final_reg", a, m_shadow[a]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
